// File: rtl/apple1_reset_ctrl.sv
// apple1_reset_ctrl
// Cleans up the two front-panel pushbuttons and sequences the apple1 reset:
// power-on reset after rst, button reset with a minimum low time, and a
// fixed-width clear-screen pulse per accepted clear-button press.
//
// Ports
//   clk25          in   system clock, all logic on the rising edge
//   rst            in   synchronous active-high reset
//   btn_reset_n    in   raw reset pushbutton, active-low, asynchronous, bouncing
//   btn_clr_n      in   raw clear-screen pushbutton, active-low, asynchronous, bouncing
//   rst_n          out  registered active-low reset to the apple1 system
//   clr_screen_btn out  registered active-high clear-screen request
//
// state          | meaning
// ST_POR         | power-on reset, rst_n low for POR_CYCLES
// ST_RUN         | system running, rst_n high
// ST_BTN_HOLD    | reset button held (accepted), rst_n low
// ST_BTN_STRETCH | button released, rst_n kept low for RST_MIN_CYCLES

module apple1_reset_ctrl #(
  parameter int DEBOUNCE_CYCLES  = 250000,
  parameter int POR_CYCLES       = 65536,
  parameter int RST_MIN_CYCLES   = 1024,
  parameter int CLR_PULSE_CYCLES = 16
) (
  input  logic clk25,
  input  logic rst,
  input  logic btn_reset_n,
  input  logic btn_clr_n,
  output logic rst_n,
  output logic clr_screen_btn
);

  localparam int MAX_AB = (DEBOUNCE_CYCLES > POR_CYCLES) ? DEBOUNCE_CYCLES : POR_CYCLES;
  localparam int MAX_CD = (RST_MIN_CYCLES > CLR_PULSE_CYCLES) ? RST_MIN_CYCLES : CLR_PULSE_CYCLES;
  localparam int MAXP   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAXP + 1);

  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] POR_LAST = CW'(POR_CYCLES - 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_MIN_CYCLES - 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_PULSE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_POR,
    ST_RUN,
    ST_BTN_HOLD,
    ST_BTN_STRETCH
  } state_t;

  // Index 0 = reset button, index 1 = clear button; level 1 = released.
  logic [1:0]    sync1_q, sync1_d;
  logic [1:0]    sync2_q, sync2_d;
  logic [1:0]    acc_q, acc_d;
  logic [CW-1:0] db_cnt_q [2];
  logic [CW-1:0] db_cnt_d [2];

  state_t        state_q, state_d;
  logic [CW-1:0] fsm_cnt_q, fsm_cnt_d;
  logic          rst_n_q, rst_n_d;

  logic          clr_prev_q, clr_prev_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] pulse_cnt_q, pulse_cnt_d;
  logic          clr_edge;

  // Synchronizers and debouncers
  always_comb begin
    sync1_d = {btn_clr_n, btn_reset_n};
    sync2_d = sync1_q;
    for (int i = 0; i < 2; i++) begin
      acc_d[i]    = acc_q[i];
      db_cnt_d[i] = '0;
      if (sync2_q[i] != acc_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          acc_d[i] = sync2_q[i];
        end else if (db_cnt_q[i] != CNT_MAX) begin
          db_cnt_d[i] = db_cnt_q[i] + CNT_ONE;
        end else begin
          db_cnt_d[i] = db_cnt_q[i];
        end
      end
    end
  end

  // Control FSM; one shared counter serves both POR and stretch timing
  always_comb begin
    state_d   = state_q;
    fsm_cnt_d = '0;
    unique case (state_q)
      ST_POR: begin
        if (fsm_cnt_q == POR_LAST) begin
          state_d = ST_RUN;
        end else if (fsm_cnt_q != CNT_MAX) begin
          fsm_cnt_d = fsm_cnt_q + CNT_ONE;
        end else begin
          fsm_cnt_d = fsm_cnt_q;
        end
      end
      ST_RUN: begin
        if (!acc_q[0]) state_d = ST_BTN_HOLD;
      end
      ST_BTN_HOLD: begin
        if (acc_q[0]) state_d = ST_BTN_STRETCH;
      end
      ST_BTN_STRETCH: begin
        if (!acc_q[0]) begin
          state_d = ST_BTN_HOLD;
        end else if (fsm_cnt_q == RST_LAST) begin
          state_d = ST_RUN;
        end else if (fsm_cnt_q != CNT_MAX) begin
          fsm_cnt_d = fsm_cnt_q + CNT_ONE;
        end else begin
          fsm_cnt_d = fsm_cnt_q;
        end
      end
      default: state_d = ST_POR;
    endcase
    rst_n_d = (state_d == ST_RUN);
  end

  // Clear-screen pulse. Gating on rst_n_d keeps the pulse aligned with the
  // registered rst_n and lets a simultaneous reset press swallow the edge.
  assign clr_edge = clr_prev_q & ~acc_q[1];

  always_comb begin
    clr_prev_d  = acc_q[1];
    pulse_d     = pulse_q;
    pulse_cnt_d = pulse_cnt_q;
    if (!rst_n_d) begin
      pulse_d     = 1'b0;
      pulse_cnt_d = '0;
    end else if (clr_edge) begin
      pulse_d     = 1'b1;
      pulse_cnt_d = '0;
    end else if (pulse_q) begin
      if (pulse_cnt_q == CLR_LAST) begin
        pulse_d     = 1'b0;
        pulse_cnt_d = '0;
      end else if (pulse_cnt_q != CNT_MAX) begin
        pulse_cnt_d = pulse_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      sync1_q     <= 2'b11;
      sync2_q     <= 2'b11;
      acc_q       <= 2'b11;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
      state_q     <= ST_POR;
      fsm_cnt_q   <= '0;
      rst_n_q     <= 1'b0;
      clr_prev_q  <= 1'b1;
      pulse_q     <= 1'b0;
      pulse_cnt_q <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      acc_q       <= acc_d;
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
      state_q     <= state_d;
      fsm_cnt_q   <= fsm_cnt_d;
      rst_n_q     <= rst_n_d;
      clr_prev_q  <= clr_prev_d;
      pulse_q     <= pulse_d;
      pulse_cnt_q <= pulse_cnt_d;
    end
  end

  assign rst_n          = rst_n_q;
  assign clr_screen_btn = pulse_q;

endmodule
